mac_array_ctrl: RTL and testbench
=================================

MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

Interface
REQ-001 SHALL have parameter row, default 8: number of tile rows; one 2-bit inst lane per row.
REQ-002 SHALL have parameter col, default 8: number of tile columns; equals kernel-load cycles.
REQ-003 SHALL have parameter len_bw, default 8: width of the execute-length field.
REQ-004 SHALL have port clk, input, 1: sole clock; all flops on posedge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: begin one load+execute job; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: synchronous job cancel.
REQ-008 SHALL have port len, input, len_bw: number of execute vectors; captured with start.
REQ-009 SHALL have port busy, output, 1: high in every non-IDLE state.
REQ-010 SHALL have port done, output, 1: single-cycle job-complete pulse.
REQ-011 SHALL have port tile_rst, output, 1: array reset pulse that re-arms the tile weight-load latch.
REQ-012 SHALL have port inst_w, output, 2*row: lane r at bits [2r+1:2r]; bit1=execute, bit0=kernel load.
REQ-013 SHALL have port l0_rd, output, 1: input-buffer read enable.
REQ-014 SHALL have port l0_addr, output, len_bw+$clog2(col)+1: input-buffer read address.
REQ-015 SHALL have port perf_cnt, output, 32: execute-cycle counter (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE->PREP->LOAD->GAP->EXEC->DRAIN->DONE->IDLE.
REQ-017 SHALL leave IDLE only on start=1 and SHALL capture len on that edge; start outside IDLE SHALL be ignored.
REQ-018 SHALL spend 1 cycle in PREP with tile_rst=1 and lane-0 inst=00.
REQ-019 SHALL spend col cycles in LOAD with lane-0 inst=01, l0_rd=1, and l0_addr counting 0..col-1.
REQ-020 SHALL spend 1 cycle in GAP with inst=00 and l0_rd=0.
REQ-021 SHALL spend len cycles in EXEC with lane-0 inst=10, l0_rd=1, and l0_addr counting col..col+len-1; len=0 SHALL go GAP->DRAIN directly.
REQ-022 SHALL spend row+col-1 cycles in DRAIN with lane-0 inst=00 and l0_rd=0.
REQ-023 SHALL spend 1 cycle in DONE with done=1, then return to IDLE; start is first accepted in the cycle after DONE.
REQ-024 SHALL drive lane r of inst_w as lane-0 inst delayed by exactly r cycles (skew matching the row stagger); lane 0 SHALL be registered (no combinational path from start).
REQ-025 SHALL raise done exactly 2*col+row+len+2 cycles after the edge that sampled start.
REQ-026 SHALL honor abort=1 in any non-IDLE state by entering IDLE next edge, flushing every skew stage to 00, deasserting l0_rd, and not pulsing done.
REQ-027 SHALL give abort priority over start when both are asserted in IDLE; the controller SHALL stay in IDLE.
REQ-028 SHALL keep l0_addr at its last value when l0_rd=0 and SHALL reset it to 0 in PREP.

Reset
REQ-029 SHALL, on reset=1, asynchronously force state=IDLE, inst_w=0, busy=0, done=0, tile_rst=0, l0_rd=0, l0_addr=0, perf_cnt=0, and captured len=0.
REQ-030 SHALL, on reset asserted mid-job, abandon the job with no done pulse; the first start after release SHALL begin a full job.

Configuration
REQ-031 SHALL, with macro MAC_CTRL_PERF_CNT_EN defined, make perf_cnt a saturating count of all EXEC cycles since reset, held across jobs.
REQ-032 SHALL, without MAC_CTRL_PERF_CNT_EN, keep the perf_cnt port and tie it to 0.

Structure
REQ-033 SHALL take from package mac_ctrl_pkg the state enum and the constants INST_IDLE=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10.
REQ-034 SHALL implement the per-lane delay line as sub-module inst_skew (parameter row, with a synchronous flush input).

Verification (row=col=8, len_bw=8)
REQ-035 SHALL cover: start with len=16 -> tile_rst high 1 cycle; lane-0 inst 01 for 8 cycles, 00 for 1, 10 for 16; done at cycle 42.
REQ-036 SHALL cover: start with len=0 -> no inst=10 on any lane; l0_addr ends at 7; done at cycle 26.
REQ-037 SHALL cover: a single job -> lane 7 shows lane-0 waveform delayed exactly 7 cycles; l0_addr sequence 0..23 for len=16.
REQ-038 SHALL cover: abort in EXEC cycle 5 -> next cycle IDLE, busy=0, all lanes 00 within 1 cycle, no done.
REQ-039 SHALL cover: start held high continuously -> back-to-back jobs with exactly one IDLE cycle between DONE and the next PREP.
REQ-040 SHALL cover: reset pulse in LOAD -> all outputs 0 immediately (asynchronous); with MAC_CTRL_PERF_CNT_EN, two len=16 jobs -> perf_cnt=32.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared types and constants for the MAC array controller.
//   state_t    - controller FSM states
//   INST_*     - 2-bit per-lane tile instruction codes (bit1 execute, bit0 load)
//   l0_addr_w  - width of the input-buffer read address
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_LOAD,
    ST_GAP,
    ST_EXEC,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Room for col load addresses followed by up to 2^len_bw execute addresses.
  function automatic int l0_addr_w(input int len_bw, input int col);
    return len_bw + $clog2(col) + 1;
  endfunction

endpackage

// File: rtl/mac_array_ctrl_if.sv
// mac_array_ctrl_if: job handshake and array/buffer control bundle.
//   master : host side  - drives start, abort, len; observes the rest
//   slave  : controller - drives busy, done, tile_rst, inst_w, l0_rd,
//            l0_addr, perf_cnt
interface mac_array_ctrl_if
  import mac_ctrl_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) ();

  localparam int ADDR_W = l0_addr_w(len_bw, col);

  logic              start;
  logic              abort;
  logic [len_bw-1:0] len;
  logic              busy;
  logic              done;
  logic              tile_rst;
  logic [2*row-1:0]  inst_w;
  logic              l0_rd;
  logic [ADDR_W-1:0] l0_addr;
  logic [31:0]       perf_cnt;

  modport master (
    output start, abort, len,
    input  busy, done, tile_rst, inst_w, l0_rd, l0_addr, perf_cnt
  );

  modport slave (
    input  start, abort, len,
    output busy, done, tile_rst, inst_w, l0_rd, l0_addr, perf_cnt
  );

endinterface

// File: rtl/mac_array_ctrl_inst_skew.sv
// inst_skew: per-row instruction delay line.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous clear of every stage to INST_IDLE
//   inst_in    : lane-0 instruction for the next cycle
//   inst_w     : lane r at [2r+1:2r], equal to lane 0 delayed by r cycles
// Stage 0 is itself a register, so lane 0 is one cycle behind inst_in.
module inst_skew
  import mac_ctrl_pkg::*;
#(
  parameter int row = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       inst_in,
  output logic [2*row-1:0] inst_w
);

  genvar gi;
  generate
    for (gi = 0; gi < row; gi++) begin : g_lane
      logic [1:0] stage_reg;
      logic [1:0] stage_in;

      if (gi == 0) begin : g_head
        assign stage_in = inst_in;
      end else begin : g_tail
        assign stage_in = g_lane[gi-1].stage_reg;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage_reg <= INST_IDLE;
        end else if (flush) begin
          stage_reg <= INST_IDLE;
        end else begin
          stage_reg <= stage_in;
        end
      end

      assign inst_w[2*gi +: 2] = stage_reg;
    end
  endgenerate

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequences one kernel-load + execute job on a row x col
// MAC tile array: PREP (tile reset) -> LOAD (col cycles) -> GAP ->
// EXEC (len cycles) -> DRAIN (row+col-1 cycles) -> DONE.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mac_array_ctrl_if.slave (start/abort/len in; busy, done,
//                tile_rst, inst_w, l0_rd, l0_addr, perf_cnt out)
// Array-facing outputs are registered from the decoded state, so they
// trail the FSM state by one cycle; busy is the state itself.
// Build option: define MAC_CTRL_PERF_CNT_EN to enable the saturating
// EXEC-cycle counter on perf_cnt (otherwise perf_cnt reads 0).
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input logic             clk,
  input logic             reset,
  mac_array_ctrl_if.slave bus
);

  localparam int ADDR_W = l0_addr_w(len_bw, col);
  localparam logic [ADDR_W-1:0] LOAD_LAST  = ADDR_W'(col - 1);
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(row + col - 2);
  localparam logic [ADDR_W-1:0] EXEC_BASE  = ADDR_W'(col);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [len_bw-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] exec_last;

  logic              tile_rst_next, l0_rd_next, done_next;
  logic [1:0]        inst_next;
  logic [ADDR_W-1:0] addr_next;
  logic              tile_rst_reg, l0_rd_reg, done_reg;
  logic [ADDR_W-1:0] l0_addr_reg;

  assign exec_last = ADDR_W'(len_reg) - ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    tile_rst_next = 1'b0;
    l0_rd_next    = 1'b0;
    done_next     = 1'b0;
    inst_next     = INST_IDLE;
    addr_next     = l0_addr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next = ST_PREP;
          len_next   = bus.len;
        end
      end
      ST_PREP: begin
        state_next    = ST_LOAD;
        tile_rst_next = 1'b1;
        addr_next     = '0;
      end
      ST_LOAD: begin
        if (cnt_reg == LOAD_LAST) state_next = ST_GAP;
        inst_next  = INST_LOAD;
        l0_rd_next = 1'b1;
        addr_next  = cnt_reg;
      end
      ST_GAP: begin
        state_next = (len_reg == '0) ? ST_DRAIN : ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt_reg == exec_last) state_next = ST_DRAIN;
        inst_next  = INST_EXEC;
        l0_rd_next = 1'b1;
        addr_next  = EXEC_BASE + cnt_reg;
      end
      ST_DRAIN: begin
        if (cnt_reg == DRAIN_LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort cancels the job outright: no further array activity, no done.
    if (bus.abort) begin
      if (state_reg != ST_IDLE) state_next = ST_IDLE;
      tile_rst_next = 1'b0;
      l0_rd_next    = 1'b0;
      done_next     = 1'b0;
      inst_next     = INST_IDLE;
      addr_next     = l0_addr_reg;
    end

    // cnt counts cycles spent in the current state, from 0.
    if (state_next != state_reg || state_reg == ST_IDLE) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_rst_reg <= 1'b0;
      l0_rd_reg    <= 1'b0;
      done_reg     <= 1'b0;
      l0_addr_reg  <= '0;
    end else begin
      tile_rst_reg <= tile_rst_next;
      l0_rd_reg    <= l0_rd_next;
      done_reg     <= done_next;
      l0_addr_reg  <= addr_next;
    end
  end

  // Lane 0 is the first skew stage; later stages follow the row stagger.
  inst_skew #(
    .row(row)
  ) u_inst_skew (
    .clk    (clk),
    .reset  (reset),
    .flush  (bus.abort),
    .inst_in(inst_next),
    .inst_w (bus.inst_w)
  );

  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.done     = done_reg;
  assign bus.tile_rst = tile_rst_reg;
  assign bus.l0_rd    = l0_rd_reg;
  assign bus.l0_addr  = l0_addr_reg;

`ifdef MAC_CTRL_PERF_CNT_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reg <= '0;
    end else if (state_reg == ST_EXEC && perf_reg != '1) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign bus.perf_cnt = perf_reg;
`else
  assign bus.perf_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: self-checking bench for mac_array_ctrl (row=col=8).
// Observation convention: the edge that samples start is edge S; "k" is
// the sample taken on the falling edge after edge S+k.
module tb_mac_array_ctrl;
  import mac_ctrl_pkg::*;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int LBW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   prev_addr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_array_ctrl_if #(.row(ROW), .col(COL), .len_bw(LBW)) bus ();

  mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int len;
    int done_k;
    int last_addr;
    int exec_cnt;
    int tile_cnt;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference waveform of one job, from the phase lengths alone.
  function automatic int job_len(input int l);
    return 2 * COL + ROW + l + 2;
  endfunction

  function automatic logic [1:0] lane0_at(input int k, input int l);
    if (k >= 2 && k <= COL + 1) return INST_LOAD;
    if (k >= COL + 3 && k <= COL + 2 + l) return INST_EXEC;
    return INST_IDLE;
  endfunction

  function automatic logic [2*ROW-1:0] inst_at(input int k, input int l);
    logic [2*ROW-1:0] v;
    for (int r = 0; r < ROW; r++) v[2*r +: 2] = lane0_at(k - r, l);
    return v;
  endfunction

  function automatic int addr_at(input int k, input int l, input int prev);
    if (k <= 0) return prev;
    if (k == 1) return 0;
    if (k <= COL + 1) return k - 2;
    if (l == 0 || k <= COL + 2) return COL - 1;
    if (k <= COL + 2 + l) return k - 3;
    return COL + l - 1;
  endfunction

  task automatic launch(input int l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LBW'(l);
    @(posedge clk);
  endtask

  // Full per-cycle comparison; start/len are randomised while the job runs
  // and must be ignored.
  task automatic run_job(input int l);
    int d;
    d = job_len(l);
    launch(l);
    for (int k = 0; k <= d + 1; k++) begin
      @(negedge clk);
      check($sformatf("busy k=%0d", k), 64'(bus.busy), 64'(k <= d - 1));
      check($sformatf("done k=%0d", k), 64'(bus.done), 64'(k == d));
      check($sformatf("tile_rst k=%0d", k), 64'(bus.tile_rst), 64'(k == 1));
      check($sformatf("l0_rd k=%0d", k), 64'(bus.l0_rd), 64'(lane0_at(k, l) != INST_IDLE));
      check($sformatf("l0_addr k=%0d", k), 64'(bus.l0_addr), 64'(addr_at(k, l, prev_addr)));
      check($sformatf("inst_w k=%0d", k), 64'(bus.inst_w), 64'(inst_at(k, l)));
      if (k < d) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.len   = LBW'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    prev_addr = addr_at(d, l, prev_addr);
    $display("job len=%0d expected done at k=%0d, checks=%0d errors=%0d", l, d, checks, errors);
  endtask

  task automatic measure_job(input int l, output int done_k, output int last_addr,
                             output int exec0, output int exec7, output int tiles);
    done_k = -1; last_addr = -1; exec0 = 0; exec7 = 0; tiles = 0;
    launch(l);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (bus.inst_w[1:0] == INST_EXEC) exec0++;
      if (bus.inst_w[2*ROW-1 -: 2] == INST_EXEC) exec7++;
      if (bus.tile_rst) tiles++;
      if (bus.done) begin
        done_k = k;
        last_addr = int'(bus.l0_addr);
        break;
      end
    end
  endtask

  task automatic wait_done(input string name, output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) begin
        t = cyc;
        break;
      end
    end
    check({name, " reached"}, 64'(t >= 0), 64'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 64'(bus.busy), 64'(0));
    check({tag, " done"}, 64'(bus.done), 64'(0));
    check({tag, " tile_rst"}, 64'(bus.tile_rst), 64'(0));
    check({tag, " l0_rd"}, 64'(bus.l0_rd), 64'(0));
    check({tag, " inst_w"}, 64'(bus.inst_w), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dk, la, e0, e7, tr, t1, t2, seen;
    int perf_exp;

    tbl[0] = '{len: 16,  done_k: 42,  last_addr: 23,  exec_cnt: 16,  tile_cnt: 1};
    tbl[1] = '{len: 0,   done_k: 26,  last_addr: 7,   exec_cnt: 0,   tile_cnt: 1};
    tbl[2] = '{len: 1,   done_k: 27,  last_addr: 8,   exec_cnt: 1,   tile_cnt: 1};
    tbl[3] = '{len: 5,   done_k: 31,  last_addr: 12,  exec_cnt: 5,   tile_cnt: 1};
    tbl[4] = '{len: 255, done_k: 281, last_addr: 262, exec_cnt: 255, tile_cnt: 1};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.len   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset l0_addr", 64'(bus.l0_addr), 64'(0));
    check("reset perf_cnt", 64'(bus.perf_cnt), 64'(0));
    reset = 1'b0;

    // Table-driven jobs
    for (int i = 0; i < 5; i++) begin
      measure_job(tbl[i].len, dk, la, e0, e7, tr);
      check($sformatf("tbl%0d done_k", i), 64'(dk), 64'(tbl[i].done_k));
      check($sformatf("tbl%0d last_addr", i), 64'(la), 64'(tbl[i].last_addr));
      check($sformatf("tbl%0d lane0 exec", i), 64'(e0), 64'(tbl[i].exec_cnt));
      check($sformatf("tbl%0d lane7 exec", i), 64'(e7), 64'(tbl[i].exec_cnt));
      check($sformatf("tbl%0d tile_rst cycles", i), 64'(tr), 64'(tbl[i].tile_cnt));
      prev_addr = tbl[i].last_addr;
      $display("tbl len=%0d done_k=%0d addr=%0d exec0=%0d exec7=%0d", tbl[i].len, dk, la, e0, e7);
    end

    // Full waveform jobs, fixed then random lengths
    run_job(16);
    run_job(0);
    for (int i = 0; i < 10; i++) run_job(int'($urandom_range(0, 40)));

    // Abort in EXEC cycle 5
    launch(16);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (COL + 6) @(posedge clk);
    @(negedge clk);
    check("abort pre lane0", 64'(bus.inst_w[1:0]), 64'(INST_EXEC));
    check("abort pre l0_addr", 64'(bus.l0_addr), 64'(COL + 3));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle_outputs("abort");
    check("abort l0_addr held", 64'(bus.l0_addr), 64'(COL + 3));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.inst_w != '0) seen = 1;
    end
    check("abort quiet afterwards", 64'(seen), 64'(0));
    prev_addr = COL + 3;
    $display("abort in EXEC cycle 5 done");

    // Abort has priority over start in IDLE
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort+start busy", 64'(bus.busy), 64'(0));
    repeat (2) @(negedge clk);
    check("abort+start tile_rst", 64'(bus.tile_rst), 64'(0));
    $display("abort+start in IDLE done");

    // Back-to-back jobs with start held high
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LBW'(3);
    wait_done("b2b first done", t1);
    check("b2b busy at done", 64'(bus.busy), 64'(0));
    @(negedge clk);
    check("b2b busy after idle", 64'(bus.busy), 64'(1));
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b second tile_rst", 64'(bus.tile_rst), 64'(1));
    wait_done("b2b second done", t2);
    check("b2b done spacing", 64'(t2 - t1), 64'(job_len(3) + 1));
    prev_addr = COL + 2;
    $display("back-to-back done spacing=%0d", t2 - t1);

    // Asynchronous reset in LOAD
    launch(16);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("async reset");
    check("async reset l0_addr", 64'(bus.l0_addr), 64'(0));
    check("async reset perf_cnt", 64'(bus.perf_cnt), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    check("reset no job resume", 64'(seen), 64'(0));
    prev_addr = 0;
    $display("reset in LOAD done");

    // Two len=16 jobs after reset
    run_job(16);
    run_job(16);
`ifdef MAC_CTRL_PERF_CNT_EN
    perf_exp = 32;
`else
    perf_exp = 0;
`endif
    check("perf_cnt", 64'(bus.perf_cnt), 64'(perf_exp));
    $display("perf_cnt=%0d", bus.perf_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
